// File: rtl/lcd_byte_tx_if.sv
// Byte request channel between the command/character sequencer and lcd_byte_tx.
// Latency: none, wires only.
// Backpressure: start is held by the requester until it is accepted (start && ready).
interface lcd_byte_tx_if;
  logic       start;
  logic       rs_in;
  logic [7:0] data_in;
  logic       long_wait;
  logic       ready;
  logic       done;

  // Requester side: drives the byte and request, watches ready/done.
  modport master (
    output start, rs_in, data_in, long_wait,
    input  ready, done
  );

  // Transmitter side: consumes the request, reports ready/done.
  modport slave (
    input  start, rs_in, data_in, long_wait,
    output ready, done
  );
endinterface

// File: rtl/lcd_byte_tx.sv
// Splits one LCD byte into two 4-bit nibble writes with E setup/pulse/hold/settle timing.
// Latency: done pulses 2*(SETUP+PULSE+HOLD)+GAP+settle cycles after the accept edge.
// Backpressure: ready only in IDLE; start while busy is ignored, never queued.
module lcd_byte_tx #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 1,
  parameter int unsigned GAP_CYC       = 50,
  parameter int unsigned WAIT_CYC      = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic               clk,
  input  logic               reset,
  lcd_byte_tx_if.slave       req,
  output logic               lcd_rs,
  output logic               lcd_e_tc,
  output logic [3:0]         config_data
);

  typedef enum logic [3:0] {
    IDLE,
    U_SETUP,
    U_PULSE,
    U_HOLD,
    GAP,
    L_SETUP,
    L_PULSE,
    L_HOLD,
    SETTLE
  } state_t;

  // Counter reload values: each timed state lasts exactly N cycles when loaded with N-1.
  localparam logic [17:0] SETUP_LD = 18'(SETUP_CYC - 1);
  localparam logic [17:0] PULSE_LD = 18'(PULSE_CYC - 1);
  localparam logic [17:0] HOLD_LD  = 18'(HOLD_CYC - 1);
  localparam logic [17:0] GAP_LD   = 18'(GAP_CYC - 1);
  localparam logic [17:0] WAIT_LD  = 18'(WAIT_CYC - 1);
  localparam logic [17:0] LWAIT_LD = 18'(LONG_WAIT_CYC - 1);

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        lw_q, lw_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        e_q, e_d;
  logic [3:0]  cfg_q, cfg_d;

  // Next-state, counter and latched-byte logic; outputs are derived from the next state
  // so every output is a flop that lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    lw_d    = lw_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (req.start) begin
        state_d = U_SETUP;
        cnt_d   = SETUP_LD;
        byte_d  = req.data_in;
        rs_d    = req.rs_in;
        lw_d    = req.long_wait;
      end
    end else if (cnt_q != 18'd0) begin
      cnt_d = cnt_q - 18'd1;
    end else begin
      unique case (state_q)
        U_SETUP: begin state_d = U_PULSE; cnt_d = PULSE_LD; end
        U_PULSE: begin state_d = U_HOLD;  cnt_d = HOLD_LD;  end
        U_HOLD:  begin state_d = GAP;     cnt_d = GAP_LD;   end
        GAP:     begin state_d = L_SETUP; cnt_d = SETUP_LD; end
        L_SETUP: begin state_d = L_PULSE; cnt_d = PULSE_LD; end
        L_PULSE: begin state_d = L_HOLD;  cnt_d = HOLD_LD;  end
        L_HOLD:  begin state_d = SETTLE;  cnt_d = lw_q ? LWAIT_LD : WAIT_LD; end
        SETTLE:  begin state_d = IDLE;    cnt_d = 18'd0;    done_d = 1'b1; end
        default: begin state_d = IDLE;    cnt_d = 18'd0;    end
      endcase
    end

    ready_d = (state_d == IDLE);
    e_d     = (state_d == U_PULSE) || (state_d == L_PULSE);

    // Upper nibble through the gap, lower nibble from L_SETUP until settle ends; IDLE holds.
    case (state_d)
      IDLE:                         cfg_d = cfg_q;
      U_SETUP, U_PULSE, U_HOLD, GAP: cfg_d = byte_d[7:4];
      default:                      cfg_d = byte_d[3:0];
    endcase
  end

  // Single state register; synchronous reset abandons any partial byte without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 18'd0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      lw_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      cfg_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      lw_q    <= lw_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      e_q     <= e_d;
      cfg_q   <= cfg_d;
    end
  end

  assign req.ready   = ready_q;
  assign req.done    = done_q;
  assign lcd_rs      = rs_q;
  assign lcd_e_tc    = e_q;
  assign config_data = cfg_q;

endmodule

// File: tb/tb_lcd_byte_tx.sv
// Directed bench for lcd_byte_tx: per-cycle comparison of all outputs against a timing model.
// Latency: expected waveforms derived from the parameter formula, cycle 0 = after accept.
// Backpressure: covers busy-time start, back-to-back accept at done, and mid-transfer reset.
module tb_lcd_byte_tx;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int G  = 50;
  localparam int W  = 2000;
  localparam int LW = 5000;
  localparam int LO = S + P + H + G;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_e_tc;
  logic [3:0] config_data;

  int checks   = 0;
  int failures = 0;

  lcd_byte_tx_if bus ();

  lcd_byte_tx #(
    .SETUP_CYC    (S),
    .PULSE_CYC    (P),
    .HOLD_CYC     (H),
    .GAP_CYC      (G),
    .WAIT_CYC     (W),
    .LONG_WAIT_CYC(LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .lcd_rs     (lcd_rs),
    .lcd_e_tc   (lcd_e_tc),
    .config_data(config_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Packed view {done, ready, e, rs, nibble}.
  function automatic logic [7:0] obs_vec();
    return {bus.done, bus.ready, lcd_e_tc, lcd_rs, config_data};
  endfunction

  function automatic logic [7:0] exp_vec(input int k, input logic [7:0] d, input logic rs,
                                         input int dc);
    logic       e;
    logic [3:0] nib;
    e   = ((k >= S) && (k < S + P)) || ((k >= LO + S) && (k < LO + S + P));
    nib = (k < LO) ? d[7:4] : d[3:0];
    return {(k == dc), (k == dc), e, rs, nib};
  endfunction

  // Checks cycles 0..done of one byte; returns at the sample point of the done cycle.
  task automatic run_xfer(input string tag, input logic [7:0] d, input logic rs, input logic lw,
                          input int busy_cyc, input bit scramble);
    int dc;
    dc = 2 * (S + P + H) + G + (lw ? LW : W);
    for (int k = 0; k <= dc; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, k), 32'(obs_vec()), 32'(exp_vec(k, d, rs, dc)));
      if (k < dc) begin
        @(posedge clk);
        #1;
        if (scramble) begin
          bus.data_in   = 8'($urandom);
          bus.rs_in     = 1'($urandom);
          bus.long_wait = 1'($urandom);
        end
        if (busy_cyc >= 0) begin
          bus.start = (k + 1 == busy_cyc);
          if (k + 1 == busy_cyc) bus.data_in = 8'hFF;
        end
      end
    end
  endtask

  task automatic idle_check(input string tag, input int n, input logic [3:0] nib, input logic rs);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, k), 32'(obs_vec()), 32'({1'b0, 1'b1, 1'b0, rs, nib}));
    end
  endtask

  // Presents a byte while the DUT is idle; returns just after the accept edge (cycle 0).
  task automatic start_byte(input logic [7:0] d, input logic rs, input logic lw);
    bus.start     = 1'b1;
    bus.data_in   = d;
    bus.rs_in     = rs;
    bus.long_wait = lw;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.data_in   = 8'h00;
    bus.rs_in     = 1'b0;
    bus.long_wait = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state holds while idle.
    idle_check("rst_idle", 10, 4'h0, 1'b0);

    // Character 'H', normal settle.
    start_byte(8'h48, 1'b1, 1'b0);
    run_xfer("b48", 8'h48, 1'b1, 1'b0, -1, 1'b0);
    idle_check("post48", 3, 4'h8, 1'b1);

    // Clear display with long settle; a start pulse at cycle 500 must be ignored.
    start_byte(8'h01, 1'b0, 1'b1);
    run_xfer("b01", 8'h01, 1'b0, 1'b1, 500, 1'b0);
    idle_check("post01", 20, 4'h1, 1'b0);

    // Back-to-back with start held: second byte accepted on the done edge.
    bus.start     = 1'b1;
    bus.data_in   = 8'h28;
    bus.rs_in     = 1'b0;
    bus.long_wait = 1'b0;
    @(posedge clk);
    #1;
    bus.data_in = 8'h0C;
    run_xfer("b28", 8'h28, 1'b0, 1'b0, -1, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    run_xfer("b0C", 8'h0C, 1'b0, 1'b0, -1, 1'b0);
    idle_check("post0C", 3, 4'hC, 1'b0);

    // Reset during the upper E pulse: E drops, ready returns, no done ever follows.
    start_byte(8'h5A, 1'b1, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_c%0d", k), 32'(obs_vec()), 32'(exp_vec(k, 8'h5A, 1'b1, 2080)));
      if (k < 5) begin
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check("rst_mid", 2100, 4'h0, 1'b0);

    // Inputs churn every cycle after accept; outputs follow the captured byte only.
    start_byte(8'hA7, 1'b1, 1'b0);
    run_xfer("bA7", 8'hA7, 1'b1, 1'b0, -1, 1'b1);
    bus.data_in   = 8'h00;
    bus.rs_in     = 1'b0;
    bus.long_wait = 1'b0;
    idle_check("postA7", 3, 4'h7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_byte_tx.md
# lcd_byte_tx

Byte-level transmit sequencer for the Spartan-3E character LCD in 4-bit mode. It accepts one 8-bit command or character byte per handshake and splits it into upper and lower nibbles. It generates the `lcd_e_tc` enable pulse and the `config_data` nibble with datasheet setup, pulse, hold and settle timing, and drives the RS select consumed by the LCD signal mux. It sits between the post-initialization command/character FSM and the signal controller, and is only used after `initialization_done`.

## Interface
- `SETUP_CYC`, 2: cycles the nibble/RS are stable before E rises (≥40 ns at 50 MHz); ≥1.
- `PULSE_CYC`, 12: cycles E is high (≥230 ns); ≥1.
- `HOLD_CYC`, 1: cycles E is low with data held after the falling edge; ≥1.
- `GAP_CYC`, 50: cycles between the upper-nibble hold and the lower-nibble setup (1 µs); ≥1.
- `WAIT_CYC`, 2000: settle cycles after the lower nibble for normal bytes (40 µs); ≥1.
- `LONG_WAIT_CYC`, 82000: settle cycles for clear/home commands (1.64 ms); ≥1, <2^18.
- `clk` in 1: 50 MHz system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; a byte is accepted on a rising edge where `start && ready`.
- `rs_in` in 1: 0 = command, 1 = character data; sampled at accept.
- `data_in` in 8: byte to send; sampled at accept.
- `long_wait` in 1: 1 selects `LONG_WAIT_CYC` settle; sampled at accept.
- `ready` out 1: high in IDLE only.
- `done` out 1: one-cycle pulse when a byte's settle time completes.
- `lcd_rs` out 1: RS for the signal mux; holds the latched `rs_in` for the whole transfer.
- `lcd_e_tc` out 1: LCD enable, drives the `lcd_e_tc` input of the signal controller.
- `config_data` out 4: nibble currently presented to the LCD bus.

## Operation
- All outputs are registered. Reset values: `ready`=1, `done`=0, `lcd_rs`=0, `lcd_e_tc`=0, `config_data`=4'h0. The state is IDLE and the counter is 0.
- States: IDLE → U_SETUP → U_PULSE → U_HOLD → GAP → L_SETUP → L_PULSE → L_HOLD → SETTLE → IDLE.
- A single 18-bit down-counter is loaded with (N−1) on entry to each timed state. The FSM advances when the counter is 0, so each state lasts exactly its parameter N cycles.
- At accept: latch `data_in`, `rs_in` and `long_wait`, then go to U_SETUP.
- U_* states: `config_data`=byte[7:4]. L_* states: `config_data`=byte[3:0]. GAP keeps byte[7:4].
- `lcd_e_tc`=1 only in U_PULSE and L_PULSE.
- SETTLE lasts `WAIT_CYC`, or `LONG_WAIT_CYC` if `long_wait` was latched. `config_data` holds byte[3:0].
- On SETTLE expiry: return to IDLE, with `ready`=1 and `done`=1 in that same first IDLE cycle.
- In IDLE, `config_data` and `lcd_rs` keep their last values and `lcd_e_tc`=0.
- `start` while `ready`=0 is ignored and not queued. The requester holds `start` until it sees accept.
- Back-to-back transfers: `start` held high in the `done` cycle is accepted at that edge.
- `reset` mid-transfer: the next edge forces reset values. E drops immediately, no `done` is issued, and the partial byte is discarded.
- `data_in`, `rs_in` and `long_wait` may change freely after accept.

## Timing
- Cycle 0 = first cycle after the accept edge. Figures below use default parameters.
- U_SETUP cycles 0–1. E high cycles 2–13 (12 cycles). U_HOLD cycle 14. GAP cycles 15–64.
- L_SETUP cycles 65–66. E high cycles 67–78. L_HOLD cycle 79. SETTLE cycles 80–2079.
- `done`=1 and `ready`=1 at cycle 2080, so the normal byte period is 2081 cycles accept-to-accept.
- With `long_wait`=1: SETTLE cycles 80–82079, `done` at cycle 82080.
- General formula: `done` cycle = 2·(SETUP+PULSE+HOLD) + GAP + settle.

## Test plan
- Reset, then idle 10 cycles → `ready`=1, `lcd_e_tc`=0, `config_data`=0, `lcd_rs`=0, `done`=0 throughout.
- Send `data_in`=8'h48, `rs_in`=1 → `config_data`=4 with E high on cycles 2–13, then `config_data`=8 with E high on cycles 67–78. `lcd_rs`=1 throughout. `done` pulses only at cycle 2080.
- Send 8'h01, `rs_in`=0, `long_wait`=1 → `done` at cycle 82080. Pulse `start` while busy at cycle 500 → ignored, still exactly one `done`.
- Hold `start` high continuously with bytes 8'h28 then 8'h0C → second accept at the `done` edge (cycle 2080 of byte 1). Exactly two E pulse pairs, with nibbles 2,8 then 0,C.
- Assert `reset` for 1 cycle at cycle 5 (during U_PULSE) → `lcd_e_tc`=0 from cycle 6, `ready`=1, and no `done` afterwards. A new byte then transfers normally.
- Change `data_in`/`rs_in` every cycle after accept → emitted nibbles and RS match the values captured at the accept edge.
